dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Target-side data-memory model for the multi-cycle and stall-for-memory cores.
- Accepts single-beat read and write requests on the dmem request/ready interface that the cores drive.
- Holds a word-addressed storage array, applies byte strobes, and returns a one-cycle ready pulse after a programmable number of wait states.
- Used in core testbenches and FPGA builds to exercise the cores' stall paths.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- DEPTH_WORDS, 1024, storage depth in words; power of two.
- WAIT_CYCLES, 2, fixed wait states between acceptance and ready (0 allowed).
- LFSR_SEED, 16'hACE1, non-zero seed for the optional random stall LFSR.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- dmem_addr_i  in  ADDR_WIDTH  byte address.
- dmem_wdata_i  in  DATA_WIDTH  write data.
- dmem_wstrb_i  in  DATA_WIDTH/8  byte write enables.
- dmem_write_i  in  1  write request.
- dmem_read_i  in  1  read request.
- dmem_rdata_o  out  DATA_WIDTH  read data.
- dmem_ready_o  out  1  completion pulse for the accepted request.
- busy_o  out  1  high while a request is in flight (WAIT state).

Behaviour:
- Decided interface fact: one clock, clk; reset rst is synchronous and active-high.
- Reset values: dmem_ready_o=0, dmem_rdata_o=0, busy_o=0, state=IDLE, wait counter=0, LFSR=LFSR_SEED.
- Reset does not clear the storage array. The array is zero-initialised at time 0 only.
- Word index = dmem_addr_i[$clog2(DEPTH_WORDS)+1:2].
  - addr[1:0] is ignored.
  - Upper address bits are ignored, so addresses alias (wrap) modulo DEPTH_WORDS*4.
- States:
  - IDLE: no request in flight.
  - WAIT: wait counter counting.
  - RESP: dmem_ready_o=1 for exactly this cycle.
- Acceptance:
  - A request (read_i or write_i high) is sampled only in IDLE or RESP.
  - On acceptance, latch addr, wdata, wstrb and the op. Load counter = WAIT_CYCLES (+ extra, see Optional Feature).
  - Requests arriving in WAIT are ignored with no side effect. Issuing one is a protocol violation by the initiator.
- Transitions:
  - IDLE/RESP + request, counter load 0 -> RESP next cycle (ready 1 cycle after the request cycle).
  - IDLE/RESP + request, counter load >0 -> WAIT.
  - WAIT: counter decrements each cycle; when it reaches 1 -> RESP. Ready therefore occurs exactly WAIT_CYCLES+1 cycles after the request cycle.
  - RESP with no new request -> IDLE.
  - Back-to-back requests are allowed: a request in the RESP cycle is accepted.
- Write:
  - Array update is performed on the clock edge entering RESP.
  - Only bytes with wstrb=1 are written; wstrb=0 means no change.
  - dmem_rdata_o is unchanged on a write.
- Read:
  - dmem_rdata_o = array[index], registered on the edge entering RESP.
  - rdata holds that value until the next read completes.
  - Read data reflects all writes that completed before it.
- Simultaneous read_i and write_i: treated as a write only. One ready pulse; rdata unchanged.
- busy_o = (state == WAIT).
- Reset mid-operation: the pending request is dropped, no ready is issued, and a pending write is not committed.

Optional Feature:
- Macro: DMEM_RESPONDER_LFSR_STALL_EN.
- Defined:
  - Add a 16-bit Fibonacci LFSR with taps 16,14,13,11, stepped once per accepted request.
  - Extra wait states = LFSR[1:0] (0-3), sampled before the step and added to WAIT_CYCLES.
  - The sequence is deterministic from LFSR_SEED and resets to the seed on rst.
- Undefined: latency is exactly WAIT_CYCLES+1 and no LFSR logic is present.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write addr 0x10, data 0xDEADBEEF, wstrb 4'hF -> ready exactly 3 cycles later.
  - Read 0x10 -> ready after 3 cycles with rdata=0xDEADBEEF.
- Byte strobes:
  - Prior word 0xDEADBEEF; write 0x11223344 with wstrb 4'b0101 -> subsequent read returns 0xDE22BE44.
- WAIT_CYCLES=0 back-to-back:
  - Read requests to 0x0, 0x4, 0x8 each issued in the ready cycle of the previous -> ready high 3 consecutive cycles with correct data each.
- Aliasing and misalignment, DEPTH_WORDS=1024:
  - Write 0xA5A5A5A5 to 0x1000 -> read of 0x0000 returns 0xA5A5A5A5.
  - Read of 0x0003 returns the same word.
- Protocol edge cases:
  - Read asserted during WAIT -> ignored; exactly one ready occurs.
  - rst asserted in the middle of a pending write to 0x20 -> no ready; a read of 0x20 after reset returns the old value; dmem_rdata_o=0 immediately after reset.
- DMEM_RESPONDER_LFSR_STALL_EN defined, seed 16'hACE1:
  - 8 reads -> each latency equals WAIT_CYCLES+1+LFSR[1:0], matching a reference LFSR model; latency returns to the seed-based sequence after rst.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory target model: word-addressed storage with byte strobes and a ready pulse after wait states.
// Define DMEM_RESPONDER_LFSR_STALL_EN to add 0-3 pseudo-random extra wait states per request.
module dmem_responder #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
    input  logic                    dmem_write_i,
    input  logic                    dmem_read_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_ready_o,
    output logic                    busy_o
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(WAIT_CYCLES + 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next, load;
    logic                req, accept, commit;

    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  write_q;

    logic [IDX_W-1:0]      op_idx;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [STRB_W-1:0]     op_wstrb;
    logic                  op_write;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS] = '{default: '0};

    // Byte offset and aliasing upper bits take no part in word selection.
    logic addr_unused;
    assign addr_unused = ^{dmem_addr_i[ADDR_WIDTH-1:IDX_W+2], dmem_addr_i[1:0]};

    assign req    = dmem_write_i | dmem_read_i;
    assign accept = req && (state != WAIT);

`ifdef DMEM_RESPONDER_LFSR_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign load    = CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr[1:0]);

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (accept)
            lfsr <= {lfsr_fb, lfsr[15:1]};
    end
`else
    localparam logic [15:0] seed_unused = LFSR_SEED;
    assign load = CNT_W'(WAIT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // op_* describes the request that completes on this edge: either the
    // latched one finishing its wait or a zero-wait request taken directly.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        op_idx     = idx_q;
        op_wdata   = wdata_q;
        op_wstrb   = wstrb_q;
        op_write   = write_q;
        case (state)
            IDLE, RESP: begin
                state_next = IDLE;
                if (req) begin
                    if (load == '0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                        op_idx     = dmem_addr_i[IDX_W+1:2];
                        op_wdata   = dmem_wdata_i;
                        op_wstrb   = dmem_wstrb_i;
                        op_write   = dmem_write_i;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = load;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                    cnt_next   = '0;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= dmem_addr_i[IDX_W+1:2];
            wdata_q <= dmem_wdata_i;
            wstrb_q <= dmem_wstrb_i;
            write_q <= dmem_write_i;
        end
    end

    // A write beats a simultaneous read; reset drops any pending commit.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_write) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (op_wstrb[b])
                    mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            dmem_rdata_o <= '0;
        else if (commit && !op_write)
            dmem_rdata_o <= mem[op_idx];
    end

    assign dmem_ready_o = (state == RESP);
    assign busy_o       = (state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: one instance with 2 wait states, one with 0.
module tb_dmem_responder;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic        write [2];
    logic        read  [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        busy  [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem   [2][DEPTH];
    logic [31:0] ref_rdata [2];
    logic [15:0] ref_lfsr  [2];
    int          wait_cfg  [2] = '{2, 0};

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(2), .LFSR_SEED(SEED)) dut_w2 (
        .clk(clk), .rst(rst),
        .dmem_addr_i(addr[0]), .dmem_wdata_i(wdata[0]), .dmem_wstrb_i(wstrb[0]),
        .dmem_write_i(write[0]), .dmem_read_i(read[0]),
        .dmem_rdata_o(rdata[0]), .dmem_ready_o(ready[0]), .busy_o(busy[0])
    );

    dmem_responder #(.WAIT_CYCLES(0), .LFSR_SEED(SEED)) dut_w0 (
        .clk(clk), .rst(rst),
        .dmem_addr_i(addr[1]), .dmem_wdata_i(wdata[1]), .dmem_wstrb_i(wstrb[1]),
        .dmem_write_i(write[1]), .dmem_read_i(read[1]),
        .dmem_rdata_o(rdata[1]), .dmem_ready_o(ready[1]), .busy_o(busy[1])
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic [15:0] bit0;
        bit0 = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'h1;
        return (x >> 1) | (bit0 << 15);
    endfunction

    // Expected latency of the next accepted request; advances the stall sequence.
    task automatic accept_model(input int u, output int lat);
        int extra;
        extra = 0;
`ifdef DMEM_RESPONDER_LFSR_STALL_EN
        extra = int'(ref_lfsr[u] % 4);
`endif
        ref_lfsr[u] = lfsr_next(ref_lfsr[u]);
        lat = wait_cfg[u] + 1 + extra;
    endtask

    task automatic model_complete(input int u, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'((a / 4) % DEPTH);
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[u][idx][8*b +: 8] = d[8*b +: 8];
        end else begin
            ref_rdata[u] = ref_mem[u][idx];
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            ref_lfsr[u]  = SEED;
            ref_rdata[u] = '0;
        end
    endtask

    task automatic release_inputs(input int u);
        write[u] = 1'b0;
        read[u]  = 1'b0;
    endtask

    // Issues one request at the current negedge and checks latency and read data.
    task automatic txn(input int u, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        int lat, n;
        accept_model(u, lat);
        addr[u] = a; wdata[u] = d; wstrb[u] = s; write[u] = w; read[u] = r;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            release_inputs(u);
        end while (!ready[u] && n < 40);
        total++;
        if (n != lat || ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL latency u%0d addr=%h: got %0d cycles (ready=%b), want %0d", u, a, n, ready[u], lat);
        end
        model_complete(u, w, a, d, s);
        total++;
        if (rdata[u] !== ref_rdata[u]) begin
            bad++;
            $display("FAIL rdata u%0d addr=%h: got %h, want %h", u, a, rdata[u], ref_rdata[u]);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (ready[u] !== 1'b0 || busy[u] !== 1'b0 || rdata[u] !== 32'h0) begin
                bad++;
                $display("FAIL reset_state u%0d: ready=%b busy=%b rdata=%h, want 0 0 0", u, ready[u], busy[u], rdata[u]);
            end
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_write_read();
        txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
        total++;
        if (rdata[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_read: got %h, want deadbeef", rdata[0]);
        end
    endtask

    task automatic test_strobes();
        txn(0, 1'b1, 1'b0, 32'h10, 32'h11223344, 4'b0101);
        txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
        total++;
        if (rdata[0] !== 32'hDE22BE44) begin
            bad++;
            $display("FAIL strobes: got %h, want de22be44", rdata[0]);
        end
        // Read and write together behave as a write only.
        txn(0, 1'b1, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF);
        txn(0, 1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        int lat, n;
        for (int k = 0; k < 3; k++)
            txn(1, 1'b1, 1'b0, 32'(4 * k), 32'h1000 + 32'(k * 17), 4'hF);
        accept_model(1, lat);
        addr[1] = 32'h0; read[1] = 1'b1; write[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = 32'(4 * k);
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (!ready[1]) release_inputs(1);
            end while (!ready[1] && n < 40);
            total++;
            if (n != lat || ready[1] !== 1'b1) begin
                bad++;
                $display("FAIL b2b_latency k%0d: got %0d, want %0d", k, n, lat);
            end
            model_complete(1, 1'b0, a, 32'h0, 4'h0);
            total++;
            if (rdata[1] !== ref_rdata[1]) begin
                bad++;
                $display("FAIL b2b_rdata k%0d: got %h, want %h", k, rdata[1], ref_rdata[1]);
            end
            if (k < 2) begin
                accept_model(1, lat);
                addr[1] = 32'(4 * (k + 1)); read[1] = 1'b1;
            end else begin
                release_inputs(1);
            end
        end
        @(negedge clk);
        total++;
        if (ready[1] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: ready=%b, want 0", ready[1]);
        end
    endtask

    task automatic test_alias();
        txn(0, 1'b1, 1'b0, 32'h1000, 32'hA5A5A5A5, 4'hF);
        txn(0, 1'b0, 1'b1, 32'h0000, 32'h0, 4'h0);
        total++;
        if (rdata[0] !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL alias: got %h, want a5a5a5a5", rdata[0]);
        end
        txn(0, 1'b0, 1'b1, 32'h0003, 32'h0, 4'h0);
        total++;
        if (rdata[0] !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL misalign: got %h, want a5a5a5a5", rdata[0]);
        end
    endtask

    task automatic test_wait_violation();
        int lat, n, cnt, first;
        accept_model(0, lat);
        addr[0] = 32'h10; read[0] = 1'b1; write[0] = 1'b0;
        @(negedge clk);
        addr[0] = 32'h40;
        cnt = 0; first = 0;
        for (n = 2; n <= 16; n++) begin
            @(negedge clk);
            release_inputs(0);
            if (ready[0]) begin
                cnt++;
                if (first == 0) begin
                    first = n;
                    model_complete(0, 1'b0, 32'h10, 32'h0, 4'h0);
                    total++;
                    if (rdata[0] !== ref_rdata[0]) begin
                        bad++;
                        $display("FAIL wait_violation_rdata: got %h, want %h", rdata[0], ref_rdata[0]);
                    end
                end
            end
        end
        total++;
        if (cnt != 1 || first != lat) begin
            bad++;
            $display("FAIL wait_violation: %0d readies first at %0d, want 1 at %0d", cnt, first, lat);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, cnt;
        txn(0, 1'b1, 1'b0, 32'h20, 32'h0BADF00D, 4'hF);
        accept_model(0, lat);
        addr[0] = 32'h20; wdata[0] = 32'h12345678; wstrb[0] = 4'hF; write[0] = 1'b1;
        @(negedge clk);
        release_inputs(0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++;
        if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0 || busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: rdata=%h/%h busy=%b ready=%b, want 0", rdata[0], rdata[1], busy[0], ready[0]);
        end
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready[0]) cnt++;
        end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL reset_mid_ready: got %0d pulses, want 0", cnt);
        end
        txn(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
        total++;
        if (rdata[0] !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL reset_mid_commit: got %h, want 0badf00d", rdata[0]);
        end
    endtask

    task automatic test_lfsr();
        for (int pass = 0; pass < 2; pass++) begin
            pulse_reset();
            for (int k = 0; k < 8; k++)
                txn(0, 1'b0, 1'b1, 32'(4 * k), 32'h0, 4'h0);
        end
    endtask

    task automatic test_random();
        int u, op;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            u  = i % 2;
            op = $urandom_range(0, 3);
            a  = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            txn(u, op == 0 || op == 3, op != 0, a, $urandom, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[u][i] = '0;
            addr[u] = '0; wdata[u] = '0; wstrb[u] = '0;
            release_inputs(u);
        end
        model_reset();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_strobes();
        test_back_to_back();
        test_alias();
        test_wait_violation();
        test_reset_mid_write();
        test_lfsr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
